serial_bit_feeder: RTL

Upstream stage of the serial sequence-detector path. Accepts a parallel word through a ready/load handshake and presents it MSB-first on the single-bit line `x`, holding each bit for a programmable number of clock cycles. Emits a one-cycle `bit_tick` strobe per new bit, usable as the detector's clock enable, and a `done` pulse at end of word.

---
 rtl/serial_bit_feeder_pkg.sv | 16 +
 rtl/serial_bit_feeder_timer.sv | 38 +++
 rtl/serial_bit_feeder.sv | 91 +++++++++
 3 files changed

// File: rtl/serial_bit_feeder_pkg.sv
// serial_bit_feeder_pkg
// Shared definitions for the serial sequence-detector path: the feeder FSM
// state encoding and the default word width / bit period, so the feeder and
// the downstream detector agree on bit timing.
package serial_bit_feeder_pkg;

  // Feeder FSM state encoding. 2'b11 is illegal and recovers to ST_IDLE.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  // Common defaults: bits per word and clock cycles per bit.
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DIV   = 4;

endpackage

// File: rtl/serial_bit_feeder_timer.sv
// bit_period_timer
// DIV-modulo counter that marks the first and last cycle of each bit period.
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  synchronous active-high reset
//   clear in  synchronous clear, holds the count at 0
//   en    in  count enable
//   first out count == 0
//   last  out count == DIV-1
module bit_period_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic first,
  output logic last
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  // Wraps back to 0 at DIV-1 so the count never passes the period end.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == CW'(DIV - 1)) cnt <= '0;
      else                     cnt <= cnt + CW'(1);
    end
  end

  assign first = (cnt == '0);
  assign last  = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder
// Accepts a parallel word through a ready/load handshake and presents it
// MSB-first on x, holding each bit for DIV clock cycles. bit_tick strobes in
// the first cycle of every bit (detector clock enable); done pulses for one
// cycle after the last bit period.
// Handshake: a word is accepted on a rising edge where ready=1 and load=1;
// load while ready=0 is ignored and nothing is queued.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   din      in   parallel word, sampled only on an accepted load
//   load     in   load request
//   ready    out  high in IDLE
//   x        out  serial data, MSB first, 0 outside SHIFT
//   bit_tick out  first cycle of each bit on x
//   busy     out  high in SHIFT
//   done     out  one-cycle pulse after the last bit period
module serial_bit_feeder
  import serial_bit_feeder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIV   = DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             x,
  output logic             bit_tick,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bitcnt;
  logic             first;
  logic             last;

  // Period counter is held at 0 outside SHIFT, so every word starts its
  // first bit on a fresh period.
  bit_period_timer #(.DIV(DIV)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state != ST_SHIFT),
    .en    (state == ST_SHIFT),
    .first (first),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      bitcnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            shreg  <= din;
            bitcnt <= '0;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (last) begin
            if (bitcnt == BW'(WIDTH - 1)) begin
              state <= ST_DONE;
            end else begin
              shreg  <= {shreg[WIDTH-2:0], 1'b0};
              bitcnt <= bitcnt + BW'(1);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // All outputs decode registered state only; nothing depends on load/din.
  assign ready    = (state == ST_IDLE);
  assign busy     = (state == ST_SHIFT);
  assign done     = (state == ST_DONE);
  assign x        = busy & shreg[WIDTH-1];
  assign bit_tick = busy & first;

endmodule
